// File: rtl/mipi_rx_pkg.sv
// Shared types and helpers for the MIPI CSI-2 receive lane deskew path.
package mipi_rx_pkg;

  localparam int unsigned MIPI_RX_MAX_LANES = 8;

  // Deskew controller states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ALIGN     = 2'd1,
    ST_LOCKED    = 2'd2,
    ST_WAIT_IDLE = 2'd3
  } deskew_state_e;

  // One lane's byte plus its valid, as carried through the delay line
  typedef struct packed {
    logic       valid;
    logic [7:0] data;
  } lane_beat_t;

  // Width of a per-lane delay field for a given skew tolerance
  function automatic int unsigned deskew_dw(input int unsigned max_skew);
    return $clog2(max_skew + 2);
  endfunction

endpackage

// File: rtl/mipi_rx_lane_delay_line.sv
// Byte+valid shift register with a selectable tap; tap N returns the beat
// that entered N clocks earlier, tap 0 returns an idle beat.
module mipi_rx_lane_delay_line
  import mipi_rx_pkg::*;
#(
  parameter int unsigned DEPTH = 9,
  parameter int unsigned DW    = 4
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  lane_beat_t    beat_i,
  input  logic [DW-1:0] tap_i,
  output lane_beat_t    tap_beat_c
);

  lane_beat_t [DEPTH-1:0] shift_q;
  lane_beat_t [DEPTH-1:0] shift_d;

  // Shift the new beat in at position 0
  always_comb begin
    shift_d = {shift_q[DEPTH-2:0], beat_i};
  end

  // Delay storage
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  // Tap select; out-of-range taps read as idle
  always_comb begin
    tap_beat_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (tap_i == DW'(i + 1)) begin
        tap_beat_c = shift_q[i];
      end
    end
  end

endmodule

// File: rtl/mipi_rx_lane_deskew.sv
// Multi-lane byte deskew: measures per-lane first-byte arrival at the start
// of each burst and delays early lanes so all active lanes line up.
// Optional feature: define MIPI_RX_DESKEW_ERR_EN to drive skew_err_o;
// otherwise it is tied low and error recovery happens silently.
module mipi_rx_lane_deskew
  import mipi_rx_pkg::*;
#(
  parameter  int unsigned LANES    = 4,
  parameter  int unsigned MAX_SKEW = 7,
  localparam int unsigned DW       = deskew_dw(MAX_SKEW)
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic [LANES-1:0]      lane_mask_i,
  input  logic [LANES-1:0]      bytes_valid_i,
  input  logic [LANES*8-1:0]    byte_i,
  output logic                  lane_valid_o,
  output logic [LANES*8-1:0]    lane_byte_o,
  output logic [LANES*DW-1:0]   lane_delay_o,
  output logic                  skew_err_o
);

  localparam int unsigned DEPTH = MAX_SKEW + 2;
  localparam logic [DW-1:0] CNT_MAX = DW'(MAX_SKEW + 1);

  deskew_state_e state_q, state_d;

  logic [LANES-1:0]          mask_q, mask_d;
  logic [LANES-1:0]          prev_valid_q, prev_valid_d;
  logic [LANES-1:0]          arrived_q, arrived_d;
  logic [DW-1:0]             count_q, count_d;
  logic [LANES-1:0][DW-1:0]  offset_q, offset_d;
  logic [LANES-1:0][DW-1:0]  delay_q, delay_d;
  logic                      lane_valid_q, lane_valid_d;
  logic [LANES-1:0][7:0]     lane_byte_q, lane_byte_d;
  logic                      dropped_q, dropped_d;
  logic                      err_q, err_d;

  lane_beat_t [LANES-1:0]    lane_in_c;
  lane_beat_t [LANES-1:0]    lane_tap_c;
  logic [LANES-1:0]          tap_valid_c;
  logic [LANES-1:0]          eff_mask_c;
  logic [LANES-1:0]          rise_c;
  logic [DW-1:0]             cur_count_c;
  logic [LANES-1:0][DW-1:0]  off_eff_c;
  logic [LANES-1:0][DW-1:0]  delay_calc_c;
  logic [DW-1:0]             t_last_c;
  logic                      any_rise_c;
  logic                      all_arrived_c;
  logic                      drop_c;
  logic                      timeout_c;
  logic                      goto_err_c;
  logic                      dv_all_c;
  logic                      quiet_c;
  logic                      raw_quiet_c;

  // Pack raw lane inputs into beats for the delay lines
  always_comb begin
    for (int unsigned k = 0; k < LANES; k++) begin
      lane_in_c[k].valid = bytes_valid_i[k];
      lane_in_c[k].data  = byte_i[8*k +: 8];
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    mipi_rx_lane_delay_line #(
      .DEPTH (DEPTH),
      .DW    (DW)
    ) u_delay (
      .clk_i      (clk_i),
      .reset_n_i  (reset_n_i),
      .beat_i     (lane_in_c[k]),
      .tap_i      (delay_q[k]),
      .tap_beat_c (lane_tap_c[k])
    );
  end

  // Arrival measurement, error and end-of-burst detection
  always_comb begin
    eff_mask_c    = (state_q == ST_IDLE) ? lane_mask_i : mask_q;
    cur_count_c   = (state_q == ST_ALIGN) ? count_q : '0;
    rise_c        = bytes_valid_i & ~prev_valid_q & ~arrived_q & eff_mask_c;
    any_rise_c    = |rise_c;
    all_arrived_c = (|(arrived_q | rise_c)) && ((arrived_q | rise_c) == eff_mask_c);
    drop_c        = |(arrived_q & ~bytes_valid_i);
    timeout_c     = count_q > DW'(MAX_SKEW);
    goto_err_c    = (state_q == ST_ALIGN) && (drop_c || (!all_arrived_c && timeout_c));
    t_last_c      = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      tap_valid_c[k] = lane_tap_c[k].valid;
      off_eff_c[k]   = rise_c[k] ? cur_count_c : offset_q[k];
      if ((arrived_q[k] || rise_c[k]) && (off_eff_c[k] > t_last_c)) begin
        t_last_c = off_eff_c[k];
      end
    end
    for (int unsigned k = 0; k < LANES; k++) begin
      delay_calc_c[k] = eff_mask_c[k] ? (t_last_c - off_eff_c[k] + DW'(1)) : '0;
    end
    dv_all_c    = &(tap_valid_c | ~mask_q);
    quiet_c     = ~|((bytes_valid_i | tap_valid_c) & mask_q);
    raw_quiet_c = ~|(bytes_valid_i & mask_q);
  end

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; simultaneous arrival on all lanes locks straight from IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (any_rise_c) begin
          state_d = all_arrived_c ? ST_LOCKED : ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        if (goto_err_c) begin
          state_d = ST_WAIT_IDLE;
        end else if (all_arrived_c) begin
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (quiet_c) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (raw_quiet_c) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered-output next values per state
  always_comb begin
    mask_d       = mask_q;
    prev_valid_d = bytes_valid_i;
    arrived_d    = arrived_q;
    count_d      = count_q;
    offset_d     = offset_q;
    delay_d      = delay_q;
    lane_valid_d = 1'b0;
    lane_byte_d  = '0;
    dropped_d    = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        mask_d    = lane_mask_i;
        count_d   = DW'(1);
        arrived_d = all_arrived_c ? '0 : rise_c;
        for (int unsigned k = 0; k < LANES; k++) begin
          if (rise_c[k]) begin
            offset_d[k] = '0;
          end
        end
        if (any_rise_c && all_arrived_c) begin
          delay_d = delay_calc_c;
        end
      end
      ST_ALIGN: begin
        arrived_d = arrived_q | rise_c;
        count_d   = (count_q == CNT_MAX) ? count_q : count_q + DW'(1);
        for (int unsigned k = 0; k < LANES; k++) begin
          if (rise_c[k]) begin
            offset_d[k] = count_q;
          end
        end
        if (all_arrived_c && !drop_c) begin
          delay_d = delay_calc_c;
        end
        if (all_arrived_c || goto_err_c) begin
          arrived_d = '0;
        end
`ifdef MIPI_RX_DESKEW_ERR_EN
        err_d = goto_err_c;
`endif
      end
      ST_LOCKED: begin
        lane_valid_d = dv_all_c && !dropped_q;
        dropped_d    = quiet_c ? 1'b0 : (dropped_q || !dv_all_c);
        for (int unsigned k = 0; k < LANES; k++) begin
          lane_byte_d[k] = (lane_valid_d && mask_q[k]) ? lane_tap_c[k].data : 8'h00;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mask_q       <= '0;
      prev_valid_q <= '0;
      arrived_q    <= '0;
      count_q      <= '0;
      offset_q     <= '0;
      delay_q      <= '0;
      lane_valid_q <= 1'b0;
      lane_byte_q  <= '0;
      dropped_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      mask_q       <= mask_d;
      prev_valid_q <= prev_valid_d;
      arrived_q    <= arrived_d;
      count_q      <= count_d;
      offset_q     <= offset_d;
      delay_q      <= delay_d;
      lane_valid_q <= lane_valid_d;
      lane_byte_q  <= lane_byte_d;
      dropped_q    <= dropped_d;
      err_q        <= err_d;
    end
  end

  assign lane_valid_o = lane_valid_q;
  assign lane_byte_o  = lane_byte_q;
  assign lane_delay_o = delay_q;
  assign skew_err_o   = err_q;

endmodule

// File: tb/tb_mipi_rx_lane_deskew.sv
// Scoreboard bench for mipi_rx_lane_deskew (LANES=4, MAX_SKEW=7).
module tb_mipi_rx_lane_deskew;

  localparam int LANES    = 4;
  localparam int MAX_SKEW = 7;
  localparam int DW       = 4;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [LANES-1:0]     lane_mask;
  logic [LANES-1:0]     bytes_valid;
  logic [LANES*8-1:0]   bytes_in;
  logic                 lane_valid_o;
  logic [LANES*8-1:0]   lane_byte_o;
  logic [LANES*DW-1:0]  lane_delay_o;
  logic                 skew_err_o;

  mipi_rx_lane_deskew #(.LANES(LANES), .MAX_SKEW(MAX_SKEW)) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .lane_mask_i   (lane_mask),
    .bytes_valid_i (bytes_valid),
    .byte_i        (bytes_in),
    .lane_valid_o  (lane_valid_o),
    .lane_byte_o   (lane_byte_o),
    .lane_delay_o  (lane_delay_o),
    .skew_err_o    (skew_err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    int          cyc;
    logic [31:0] b;
    logic [15:0] d;
  } beat_t;

  beat_t exp_q[$];
  int    err_exp_q[$];
  beat_t mon_b;
  int    mon_c;

  int b_start [LANES];
  int b_len   [LANES];

  function automatic logic [7:0] data_b(input int k, input int j, input logic [7:0] tag,
                                        input logic [7:0] first);
    logic [7:0] v;
    v = (j == 0) ? first : 8'(j * 17);
    return v ^ 8'(k * int'(tag));
  endfunction

  task automatic push_err(input int c);
`ifdef MIPI_RX_DESKEW_ERR_EN
    err_exp_q.push_back(c);
`else
    if (c < 0) err_exp_q.push_back(c);
`endif
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, act, req);
    end
  endtask

  // Model one burst from b_start/b_len, queue expectations, then drive it
  task automatic run_burst(input logic [3:0] mask, input logic [7:0] tag, input logic [7:0] first);
    int t0, tlast, drop_at, fin, span, n;
    bit lock;
    beat_t e;
    t0 = cyc; tlast = 0; drop_at = 1000; span = 0; n = 1000; lock = 1'b1;
    for (int k = 0; k < LANES; k++) begin
      if (b_start[k] + b_len[k] > span) span = b_start[k] + b_len[k];
      if (mask[k]) begin
        if (b_len[k] == 0) lock = 1'b0;
        else begin
          if (b_start[k] > tlast) tlast = b_start[k];
          if (b_start[k] + b_len[k] < drop_at) drop_at = b_start[k] + b_len[k];
          if (b_len[k] < n) n = b_len[k];
        end
      end
    end
    if (tlast > MAX_SKEW + 1) lock = 1'b0;
    fin = lock ? tlast : MAX_SKEW + 1;
    if (drop_at <= fin) push_err(t0 + drop_at + 1);
    else if (!lock) push_err(t0 + MAX_SKEW + 2);
    else begin
      e.d = '0;
      for (int k = 0; k < LANES; k++)
        if (mask[k]) e.d[4*k +: 4] = 4'(tlast - b_start[k] + 1);
      for (int j = 0; j < n; j++) begin
        e.cyc = t0 + tlast + 2 + j;
        e.b   = '0;
        for (int k = 0; k < LANES; k++)
          if (mask[k]) e.b[8*k +: 8] = data_b(k, j, tag, first);
        exp_q.push_back(e);
      end
    end
    lane_mask = mask;
    for (int t = 0; t < span + MAX_SKEW + 6; t++) begin
      for (int k = 0; k < LANES; k++) begin
        bytes_valid[k] = (t >= b_start[k]) && (t < b_start[k] + b_len[k]);
        bytes_in[8*k +: 8] = bytes_valid[k] ? data_b(k, t - b_start[k], tag, first) : 8'h00;
      end
      @(posedge clk); #1;
    end
  endtask

  // Monitor: pop and compare whenever the DUT presents a beat or error pulse
  always @(negedge clk) begin
    if (reset_n) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++; errors++;
        mon_b = exp_q.pop_front();
        $display("FAIL beat_missing cyc=%0d required_at=%0d", cyc, mon_b.cyc);
      end
      if (lane_valid_o) begin
        checks++;
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          errors++;
          $display("FAIL beat_unexpected cyc=%0d bytes=%h delay=%h", cyc, lane_byte_o, lane_delay_o);
        end else begin
          mon_b = exp_q.pop_front();
          if (lane_byte_o !== mon_b.b || lane_delay_o !== mon_b.d) begin
            errors++;
            $display("FAIL beat cyc=%0d bytes=%h required=%h delay=%h required=%h",
                     cyc, lane_byte_o, mon_b.b, lane_delay_o, mon_b.d);
          end
        end
      end
      while (err_exp_q.size() > 0 && err_exp_q[0] < cyc) begin
        checks++; errors++;
        mon_c = err_exp_q.pop_front();
        $display("FAIL skew_err_missing cyc=%0d required_at=%0d", cyc, mon_c);
      end
      if (skew_err_o) begin
        checks++;
        if (err_exp_q.size() == 0 || err_exp_q[0] != cyc) begin
          errors++;
          $display("FAIL skew_err_unexpected cyc=%0d got=1 required=0", cyc);
        end else begin
          mon_c = err_exp_q.pop_front();
        end
      end
    end
  end

  initial begin
    lane_mask = 4'hF; bytes_valid = '0; bytes_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", 32'(lane_valid_o), 32'h0);
    chk("reset_bytes", lane_byte_o, 32'h0);
    chk("reset_delay", 32'(lane_delay_o), 32'h0);
    chk("reset_err", 32'(skew_err_o), 32'h0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Skew scenario: lane1 first, lanes 2/3 at +4, lane0 at +5
    b_start = '{5, 0, 4, 4}; b_len = '{8, 8, 8, 8};
    run_burst(4'hF, 8'h00, 8'hB8);
    // Second burst re-measures different skew
    b_start = '{0, 2, 1, 3}; b_len = '{6, 5, 6, 4};
    run_burst(4'hF, 8'h40, 8'h5C);
    // Zero skew
    b_start = '{0, 0, 0, 0}; b_len = '{5, 5, 5, 5};
    run_burst(4'hF, 8'h21, 8'hA7);
    // Overrun: lane3 (and 1,2) never rise
    b_start = '{0, 0, 0, 0}; b_len = '{12, 0, 0, 0};
    run_burst(4'hF, 8'h00, 8'h99);
    // Lane mask 0x3 with lanes 2,3 idle
    b_start = '{1, 0, 0, 0}; b_len = '{6, 6, 0, 0};
    run_burst(4'h3, 8'h0F, 8'h3C);
    // Premature drop of an arrived lane before lock
    b_start = '{0, 0, 0, 5}; b_len = '{2, 9, 9, 9};
    run_burst(4'hF, 8'h11, 8'h77);
    // Last lane arrives exactly at the timeout count
    b_start = '{0, 0, 0, 8}; b_len = '{10, 10, 10, 10};
    run_burst(4'hF, 8'h08, 8'hE1);

    // Reset while locked: two beats seen, then everything clears at once
    begin
      int t0;
      beat_t e;
      lane_mask = 4'hF;
      t0 = cyc;
      for (int j = 0; j < 2; j++) begin
        e.cyc = t0 + 2 + j; e.d = 16'h1111; e.b = '0;
        for (int k = 0; k < LANES; k++) e.b[8*k +: 8] = data_b(k, j, 8'h33, 8'hC3);
        exp_q.push_back(e);
      end
      for (int t = 0; t < 4; t++) begin
        bytes_valid = 4'hF;
        for (int k = 0; k < LANES; k++) bytes_in[8*k +: 8] = data_b(k, t, 8'h33, 8'hC3);
        @(posedge clk); #1;
      end
      #2 reset_n = 1'b0;
      #1;
      chk("midreset_valid", 32'(lane_valid_o), 32'h0);
      chk("midreset_bytes", lane_byte_o, 32'h0);
      chk("midreset_delay", 32'(lane_delay_o), 32'h0);
      chk("midreset_err", 32'(skew_err_o), 32'h0);
      bytes_valid = '0; bytes_in = '0;
      @(posedge clk); #1 reset_n = 1'b1;
      repeat (2) @(posedge clk); #1;
    end

    // Normal alignment after reset
    b_start = '{3, 1, 0, 2}; b_len = '{5, 7, 8, 6};
    run_burst(4'hF, 8'h52, 8'h6D);

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("beats_left", 32'(exp_q.size()), 32'h0);
    chk("errs_left", 32'(err_exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
